// File: rtl/rv_pkg.sv
// Shared register-file types and constants for the RISC-V operand-fetch stage.
package rv_pkg;
  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;

  typedef logic [4:0] reg_idx_t;
  localparam reg_idx_t ZERO_IDX = '0;

  // An address is live if it names a real register that is not the hardwired zero.
  function automatic logic addr_ok(input int unsigned a, input int unsigned nreg, input logic zero);
    return (a < nreg) && !(zero && (a == 32'(ZERO_IDX)));
  endfunction
endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, issue-set beats write-clear.
module regfile_scoreboard
  import rv_pkg::*;
#(
  parameter int NREG     = NREG_DEF,
  parameter int AW       = $clog2(NREG),
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we,
  input  logic [AW-1:0]       wa,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_rd,
  input  logic [NREAD*AW-1:0] ra,
  output logic [NREAD-1:0]    busy_rd
);
  logic [NREG-1:0] busy_q, busy_d;
  logic            clr_ok, set_ok;

  assign clr_ok = we && addr_ok(32'(wa), NREG, ZERO_REG != 0);
  assign set_ok = iss_en && addr_ok(32'(iss_rd), NREG, ZERO_REG != 0);

  always_comb begin
    busy_d = busy_q;
    if (clr_ok) busy_d[wa] = 1'b0;
    if (set_ok) busy_d[iss_rd] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  // Readers see the post-clear, pre-set view so an issuer is not its own hazard.
  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [AW-1:0] a;
    assign a = ra[k*AW +: AW];
    assign busy_rd[k] = addr_ok(32'(a), NREG, ZERO_REG != 0) && busy_q[a]
                        && !(clr_ok && (wa == a));
  end
endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port integer register file with registered reads, bypass and hazard flags.
module regfile_mp
  import rv_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NREG     = NREG_DEF,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(NREG)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  re,
  input  logic [NREAD*AW-1:0]   ra,
  input  logic                  we,
  input  logic [AW-1:0]         wa,
  input  logic [XLEN-1:0]       wd,
  input  logic                  iss_en,
  input  logic [AW-1:0]         iss_rd,
  output logic [NREAD*XLEN-1:0] rd,
  output logic [NREAD-1:0]      rd_busy,
  output logic                  rd_valid
);
  logic [XLEN-1:0]             x_q [NREG];
  logic [NREAD-1:0][XLEN-1:0]  rd_q, rd_d;
  logic [NREAD-1:0]            busy_q, busy_rd;
  logic                        valid_q;
  logic                        wr_ok;

  assign wr_ok = we && addr_ok(32'(wa), NREG, ZERO_REG != 0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) x_q[i] <= '0;
    end else if (wr_ok) begin
      x_q[wa] <= wd;
    end
  end

  regfile_scoreboard #(
    .NREG(NREG), .AW(AW), .NREAD(NREAD), .ZERO_REG(ZERO_REG)
  ) u_sb (
    .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .iss_en(iss_en),
    .iss_rd(iss_rd), .ra(ra), .busy_rd(busy_rd)
  );

  // Dead addresses read zero; a matching same-cycle write forwards only when BYPASS is set.
  for (genvar k = 0; k < NREAD; k++) begin : g_port
    logic [AW-1:0] a;
    logic          ok, fwd;
    assign a   = ra[k*AW +: AW];
    assign ok  = addr_ok(32'(a), NREG, ZERO_REG != 0);
    assign fwd = (BYPASS != 0) && wr_ok && (wa == a);
    assign rd_d[k] = !ok ? '0 : (fwd ? wd : x_q[a]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q    <= '0;
      busy_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= re;
      if (re) begin
        rd_q   <= rd_d;
        busy_q <= busy_rd;
      end
    end
  end

  assign rd       = rd_q;
  assign rd_busy  = busy_q;
  assign rd_valid = valid_q;
endmodule

// File: tb/tb_regfile_mp.sv
// Directed checks on a default regfile_mp and a 20-reg/3-port read-first variant, plus a model-checked random run.
module tb_regfile_mp;
  logic        clk = 1'b0;
  logic        rst_n, re, we, iss_en;
  logic [4:0]  wa, iss_rd;
  logic [31:0] wd;
  logic [9:0]  ra_a;
  logic [14:0] ra_b;
  logic [63:0] rd_a;
  logic [95:0] rd_b;
  logic [1:0]  bz_a;
  logic [2:0]  bz_b;
  logic        v_a, v_b;
  int          n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  regfile_mp dut_a (
    .clk(clk), .rst_n(rst_n), .re(re), .ra(ra_a), .we(we), .wa(wa), .wd(wd),
    .iss_en(iss_en), .iss_rd(iss_rd), .rd(rd_a), .rd_busy(bz_a), .rd_valid(v_a)
  );

  regfile_mp #(.NREG(20), .NREAD(3), .ZERO_REG(0), .BYPASS(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .re(re), .ra(ra_b), .we(we), .wa(wa), .wd(wd),
    .iss_en(iss_en), .iss_rd(iss_rd), .rd(rd_b), .rd_busy(bz_b), .rd_valid(v_b)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    re = 0; we = 0; iss_en = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; idle(); wa = 0; wd = 0; iss_rd = 0; ra_a = 0; ra_b = 0;
    #1;
    n_chk++; if (rd_a !== 64'h0 || v_a !== 1'b0 || bz_a !== 2'b00) begin
      n_fail++; $display("FAIL reset_state: rd=%h valid=%b busy=%b exp 0/0/0", rd_a, v_a, bz_a); end
    cyc(); cyc();
    rst_n = 1;
    re = 1; ra_a = {5'd31, 5'd5}; ra_b = {5'd0, 5'd19, 5'd5};
    cyc();
    n_chk++; if (rd_a !== 64'h0 || bz_a !== 2'b00 || v_a !== 1'b1) begin
      n_fail++; $display("FAIL reset_read: rd=%h busy=%b valid=%b exp 0/00/1", rd_a, bz_a, v_a); end
    n_chk++; if (rd_b !== 96'h0 || bz_b !== 3'b000) begin
      n_fail++; $display("FAIL reset_read_b: rd=%h busy=%b exp 0", rd_b, bz_b); end
    idle();
  endtask

  task automatic test_write_read();
    we = 1; wa = 7; wd = 32'hDEADBEEF;
    cyc();
    we = 0; re = 1; ra_a = {5'd7, 5'd7}; ra_b = {5'd7, 5'd7, 5'd7};
    cyc();
    n_chk++; if (rd_a[31:0] !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL write_read: rd0=%h exp DEADBEEF", rd_a[31:0]); end
    we = 1; wa = 7; wd = 32'h1234;
    cyc();
    n_chk++; if (rd_a !== {32'h1234, 32'h1234}) begin
      n_fail++; $display("FAIL bypass_wf: rd=%h exp both 00001234", rd_a); end
    n_chk++; if (rd_b !== {3{32'hDEADBEEF}}) begin
      n_fail++; $display("FAIL bypass_rf: rd=%h exp all DEADBEEF", rd_b); end
    idle();
  endtask

  task automatic test_zero_reg();
    we = 1; wa = 0; wd = 32'hFFFFFFFF; iss_en = 1; iss_rd = 0;
    cyc();
    idle(); re = 1; ra_a = 0; ra_b = 0;
    cyc();
    n_chk++; if (rd_a[31:0] !== 32'h0 || bz_a[0] !== 1'b0) begin
      n_fail++; $display("FAIL zero_hw: rd0=%h busy0=%b exp 0/0", rd_a[31:0], bz_a[0]); end
    // Without a hardwired zero, x0 is ordinary: written, and the same-cycle issue keeps it busy.
    n_chk++; if (rd_b[31:0] !== 32'hFFFFFFFF || bz_b[0] !== 1'b1) begin
      n_fail++; $display("FAIL zero_plain: rd0=%h busy0=%b exp FFFFFFFF/1", rd_b[31:0], bz_b[0]); end
    idle();
  endtask

  task automatic test_nreg_bound();
    we = 1; wa = 19; wd = 32'h19191919;
    cyc();
    wa = 25; wd = 32'hBAD0BAD0;
    cyc();
    idle(); re = 1; ra_b = {5'd0, 5'd19, 5'd25};
    cyc();
    n_chk++; if (rd_b !== {32'hFFFFFFFF, 32'h19191919, 32'h0}) begin
      n_fail++; $display("FAIL nreg_bound: rd=%h exp FFFFFFFF_19191919_00000000", rd_b); end
    n_chk++; if (bz_b !== 3'b100) begin
      n_fail++; $display("FAIL nreg_busy: busy=%b exp 100", bz_b); end
    idle();
  endtask

  task automatic test_scoreboard();
    iss_en = 1; iss_rd = 3;
    cyc();
    iss_en = 0; re = 1; ra_a = {5'd0, 5'd3};
    cyc();
    n_chk++; if (bz_a !== 2'b01 || rd_a[31:0] !== 32'h0) begin
      n_fail++; $display("FAIL sb_set: busy=%b rd0=%h exp 01/0", bz_a, rd_a[31:0]); end
    we = 1; wa = 3; wd = 32'h55;
    cyc();
    n_chk++; if (bz_a[0] !== 1'b0 || rd_a[31:0] !== 32'h55) begin
      n_fail++; $display("FAIL sb_wb_clear: busy0=%b rd0=%h exp 0/55", bz_a[0], rd_a[31:0]); end
    wd = 32'h66; iss_en = 1; iss_rd = 3;
    cyc();
    n_chk++; if (bz_a[0] !== 1'b0 || rd_a[31:0] !== 32'h66) begin
      n_fail++; $display("FAIL sb_same_cycle: busy0=%b rd0=%h exp 0/66", bz_a[0], rd_a[31:0]); end
    we = 0; iss_en = 0;
    cyc();
    n_chk++; if (bz_a[0] !== 1'b1 || rd_a[31:0] !== 32'h66) begin
      n_fail++; $display("FAIL sb_set_wins: busy0=%b rd0=%h exp 1/66", bz_a[0], rd_a[31:0]); end
    re = 0; we = 1; wa = 3; wd = 32'h77; iss_en = 1; iss_rd = 4;
    cyc();
    idle(); re = 1; ra_a = {5'd4, 5'd3};
    cyc();
    n_chk++; if (bz_a !== 2'b10 || rd_a[31:0] !== 32'h77) begin
      n_fail++; $display("FAIL sb_diff_addr: busy=%b rd0=%h exp 10/77", bz_a, rd_a[31:0]); end
    iss_en = 1; iss_rd = 5; ra_a = {5'd5, 5'd5};
    cyc();
    n_chk++; if (bz_a !== 2'b00) begin
      n_fail++; $display("FAIL sb_self_hazard: busy=%b exp 00", bz_a); end
    idle();
  endtask

  task automatic test_hold_valid();
    we = 1; wa = 9; wd = 32'h99;
    cyc();
    we = 0; re = 1; ra_a = {5'd0, 5'd9};
    cyc();
    n_chk++; if (rd_a[31:0] !== 32'h99 || v_a !== 1'b1) begin
      n_fail++; $display("FAIL hold_first: rd0=%h valid=%b exp 99/1", rd_a[31:0], v_a); end
    re = 0;
    for (int i = 0; i < 3; i++) begin
      we = 1; wa = 9; wd = 32'hAA + 32'(i);
      cyc();
      n_chk++; if (rd_a[31:0] !== 32'h99 || v_a !== 1'b0) begin
        n_fail++; $display("FAIL hold_cycle%0d: rd0=%h valid=%b exp 99/0", i, rd_a[31:0], v_a); end
    end
    we = 0; re = 1;
    cyc();
    n_chk++; if (rd_a[31:0] !== 32'hAC || v_a !== 1'b1) begin
      n_fail++; $display("FAIL hold_reread: rd0=%h valid=%b exp AC/1", rd_a[31:0], v_a); end
    idle();
  endtask

  task automatic test_reset_mid_read();
    re = 1; ra_a = {5'd7, 5'd7};
    cyc();
    n_chk++; if (rd_a[31:0] !== 32'h1234) begin
      n_fail++; $display("FAIL pre_reset_read: rd0=%h exp 1234", rd_a[31:0]); end
    #2 rst_n = 0;
    #1;
    n_chk++; if (rd_a !== 64'h0 || v_a !== 1'b0 || bz_a !== 2'b00) begin
      n_fail++; $display("FAIL async_reset: rd=%h valid=%b busy=%b exp 0", rd_a, v_a, bz_a); end
    cyc();
    rst_n = 1;
    cyc();
    n_chk++; if (rd_a !== 64'h0 || v_a !== 1'b1) begin
      n_fail++; $display("FAIL post_reset_read: rd=%h valid=%b exp 0/1", rd_a, v_a); end
    idle();
  endtask

  task automatic test_random();
    logic [31:0] m_x [20];
    logic [19:0] m_busy;
    logic [95:0] exp_rd, nd;
    logic [2:0]  exp_bz, nb;
    logic        exp_v;
    logic [4:0]  a;
    int          errs;
    idle(); rst_n = 0;
    cyc();
    rst_n = 1;
    for (int i = 0; i < 20; i++) m_x[i] = '0;
    m_busy = '0; exp_rd = '0; exp_bz = '0; exp_v = 0; errs = 0;
    for (int c = 0; c < 3000; c++) begin
      re = ($urandom_range(0, 3) != 0); we = $urandom_range(0, 1) != 0;
      iss_en = $urandom_range(0, 1) != 0;
      wa = 5'($urandom_range(0, 31)); iss_rd = 5'($urandom_range(0, 31));
      wd = $urandom; ra_a = 10'($urandom); ra_b = 15'($urandom);
      if ($urandom_range(0, 3) == 0) ra_b[4:0] = wa;
      for (int p = 0; p < 3; p++) begin
        a = ra_b[p*5 +: 5];
        if (a < 20) begin
          nd[p*32 +: 32] = m_x[a];
          nb[p] = m_busy[a] && !(we && wa == a);
        end else begin
          nd[p*32 +: 32] = '0;
          nb[p] = 1'b0;
        end
      end
      if (re) begin exp_rd = nd; exp_bz = nb; end
      exp_v = re;
      if (we && wa < 20) begin m_x[wa] = wd; m_busy[wa] = 1'b0; end
      if (iss_en && iss_rd < 20) m_busy[iss_rd] = 1'b1;
      cyc();
      n_chk++; if (rd_b !== exp_rd) begin
        n_fail++; errs++;
        if (errs < 10) $display("FAIL rand_rd c=%0d: rd=%h exp %h", c, rd_b, exp_rd); end
      n_chk++; if (bz_b !== exp_bz || v_b !== exp_v) begin
        n_fail++; errs++;
        if (errs < 10) $display("FAIL rand_busy c=%0d: busy=%b valid=%b exp %b/%b", c, bz_b, v_b, exp_bz, exp_v); end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_zero_reg();
    test_nreg_bound();
    test_scoreboard();
    test_hold_valid();
    test_reset_mid_read();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
